// File: rtl/addsub_pkg.sv
// Shared types and op decoding for the pipelined adder/subtractor.
// ADDSUB_SAT_EN enables the signed saturating ADDS/SUBS op codes.
package addsub_pkg;

    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_SUB  = 3'b001,
        OP_SLT  = 3'b010,
        OP_SLTU = 3'b011,
        OP_ADDS = 3'b100,
        OP_SUBS = 3'b101
    } op_e;

    typedef struct packed {
        logic cout;
        logic ovf;
        logic zero;
        logic neg;
    } flags_t;

    function automatic op_e decode_op(input logic [2:0] code);
        op_e o;
        case (code)
            3'b000:  o = OP_ADD;
            3'b001:  o = OP_SUB;
            3'b010:  o = OP_SLT;
            3'b011:  o = OP_SLTU;
`ifdef ADDSUB_SAT_EN
            3'b100:  o = OP_ADDS;
            3'b101:  o = OP_SUBS;
            default: o = OP_ADD;
`else
            default: o = code[0] ? OP_SUB : OP_ADD;
`endif
        endcase
        return o;
    endfunction

    // Subtract-class ops invert B and inject a carry of 1 into segment 0.
    function automatic logic seg_carry_in(input op_e o);
        return (o == OP_SUB) || (o == OP_SLT) || (o == OP_SLTU) || (o == OP_SUBS);
    endfunction

endpackage

// File: rtl/addsub_if.sv
// Operand/result handshake bundle for addsub_pipe.
// slave = the arithmetic block, master = whoever feeds and drains it.
interface addsub_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] reg1;
    logic [WIDTH-1:0] reg2;
    logic [2:0]       op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             ovf;
    logic             zero;
    logic             neg;

    modport master (
        output in_valid, reg1, reg2, op, out_ready,
        input  in_ready, out_valid, result, cout, ovf, zero, neg
    );

    modport slave (
        input  in_valid, reg1, reg2, op, out_ready,
        output in_ready, out_valid, result, cout, ovf, zero, neg
    );
endinterface

// File: rtl/addsub_seg.sv
// One carry-chain segment: SW-bit add with carry in and carry out.
// Purely combinational; registering is done by the enclosing pipeline.
module addsub_seg #(
    parameter int SW = 16
) (
    input  logic [SW-1:0] a,
    input  logic [SW-1:0] b,
    input  logic          ci,
    output logic [SW-1:0] sum,
    output logic          co
);
    assign {co, sum} = {1'b0, a} + {1'b0, b} + {{SW{1'b0}}, ci};
endmodule

// File: rtl/addsub_pipe.sv
// Pipelined add/sub/compare, carry chain split into STAGES registered segments.
// Latency STAGES cycles, 1/cycle; global stall: all stages hold while out_valid && !out_ready.
// Optional ADDSUB_SAT_EN: signed saturating ADDS/SUBS.
module addsub_pipe
    import addsub_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input  logic      clk,
    input  logic      rst,
    addsub_if.slave   bus
);
    localparam int SW = WIDTH / STAGES;
    localparam int L  = STAGES - 1;

    // a/b ride along with the not-yet-added high bits; sum collects finished low bits.
    typedef struct packed {
        logic             vld;
        op_e              op;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] sum;
        logic             c;
        flags_t           f;
    } stage_t;

    stage_t st_q [STAGES];
    stage_t st_d [STAGES];
    stage_t src  [STAGES];

    logic [STAGES-1:0][SW-1:0] seg_sum;
    logic [STAGES-1:0]         seg_co;
    logic                      adv;
    op_e                       in_op;
    logic                      a_msb;
    logic                      b_msb;
    logic                      s_msb;
    logic                      ovf_raw;
    logic [WIDTH-1:0]          res;

    assign adv   = !st_q[L].vld || bus.out_ready;
    assign in_op = decode_op(bus.op);

    always_comb begin
        src[0].vld = bus.in_valid;
        src[0].op  = in_op;
        src[0].a   = bus.reg1;
        src[0].b   = seg_carry_in(in_op) ? ~bus.reg2 : bus.reg2;
        src[0].sum = '0;
        src[0].c   = seg_carry_in(in_op);
        src[0].f   = '0;
        for (int k = 1; k < STAGES; k++) begin
            src[k] = st_q[k-1];
        end
    end

    for (genvar g = 0; g < STAGES; g++) begin : g_seg
        addsub_seg #(.SW(SW)) u_seg (
            .a   (src[g].a[g*SW +: SW]),
            .b   (src[g].b[g*SW +: SW]),
            .ci  (src[g].c),
            .sum (seg_sum[g]),
            .co  (seg_co[g])
        );
    end

    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            st_d[k]                   = src[k];
            st_d[k].sum[k*SW +: SW]   = seg_sum[k];
            st_d[k].c                 = seg_co[k];
        end

        // The last stage resolves the final result and flags before registering them.
        a_msb   = src[L].a[WIDTH-1];
        b_msb   = src[L].b[WIDTH-1];
        s_msb   = st_d[L].sum[WIDTH-1];
        ovf_raw = (a_msb == b_msb) && (s_msb != a_msb);
        res     = st_d[L].sum;
        case (src[L].op)
            OP_SLT: begin
                res    = '0;
                res[0] = s_msb ^ ovf_raw;
            end
            OP_SLTU: begin
                res    = '0;
                res[0] = ~seg_co[L];
            end
`ifdef ADDSUB_SAT_EN
            OP_ADDS, OP_SUBS: begin
                if (ovf_raw) begin
                    res          = a_msb ? '0 : '1;
                    res[WIDTH-1] = a_msb;
                end
            end
`endif
            default: ;
        endcase
        st_d[L].sum    = res;
        st_d[L].f.cout = seg_co[L];
        st_d[L].f.ovf  = ovf_raw;
        st_d[L].f.zero = (res == '0);
        st_d[L].f.neg  = res[WIDTH-1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                st_q[k] <= '0;
            end
        end else if (adv) begin
            for (int k = 0; k < STAGES; k++) begin
                st_q[k] <= st_d[k];
            end
        end
    end

    assign bus.in_ready  = adv;
    assign bus.out_valid = st_q[L].vld;
    assign bus.result    = st_q[L].sum;
    assign bus.cout      = st_q[L].f.cout;
    assign bus.ovf       = st_q[L].f.ovf;
    assign bus.zero      = st_q[L].f.zero;
    assign bus.neg       = st_q[L].f.neg;

endmodule
